// File: rtl/ring_rr_arbiter_6.sv
// ring_rr_arbiter_6: six-way round-robin arbiter with one idle cycle between owners; define RING_ARB_TIMEOUT_EN to force-end grants after MAX_HOLD cycles
module ring_rr_arbiter_6 #(
  parameter int N = 6,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [2:0]   grant_id,
  output logic         busy,
  output logic         grant_start,
  output logic [N-1:0] prio,
  output logic         timeout
);
`ifdef RING_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [N-1:0] grant_n, prio_n;
  logic [2:0] id_n, win_id, p_idx;
  logic [3:0] hold_cnt, hold_n;
  logic busy_n, start_n, to_n, owner_req, expire;
  assign owner_req = |(req & grant);
  assign expire = TO_EN && owner_req && hold_cnt == 4'(MAX_HOLD);
  always_comb begin
    p_idx = 3'd0;
    for (int i = 0; i < N; i++) if (prio[i]) p_idx = 3'(i);
    win_id = 3'd0;
    for (int k = N - 1; k >= 0; k--) if (req[(int'(p_idx) + k) % N]) win_id = 3'((int'(p_idx) + k) % N);
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    id_n    = grant_id;
    busy_n  = busy;
    start_n = 1'b0;
    to_n    = 1'b0;
    prio_n  = prio;
    hold_n  = hold_cnt == 4'd15 ? 4'd15 : hold_cnt + 4'd1;
    if (state == IDLE) begin
      hold_n = 4'd0;
      if (|req) begin
        state_n = GRANT;
        grant_n = N'(1) << win_id;
        id_n    = win_id;
        busy_n  = 1'b1;
        start_n = 1'b1;
        hold_n  = 4'd1;
      end
    end else if (!owner_req || expire) begin
      state_n = IDLE;
      grant_n = '0;
      id_n    = 3'd0;
      busy_n  = 1'b0;
      prio_n  = {grant[N-2:0], grant[N-1]};
      to_n    = expire;
      hold_n  = 4'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= 3'd0;
      busy        <= 1'b0;
      grant_start <= 1'b0;
      timeout     <= 1'b0;
      prio        <= N'(1);
      hold_cnt    <= 4'd0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_id    <= id_n;
      busy        <= busy_n;
      grant_start <= start_n;
      timeout     <= to_n;
      prio        <= prio_n;
      hold_cnt    <= hold_n;
    end
  end
endmodule

// File: tb/tb_ring_rr_arbiter_6.sv
// tb_ring_rr_arbiter_6: directed vector bench for ring_rr_arbiter_6
module tb_ring_rr_arbiter_6;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] req = '0, grant, prio;
  logic [2:0] grant_id;
  logic busy, grant_start, timeout;
  int errors = 0, checks = 0;
  typedef struct {
    logic rst;
    logic [5:0] req, grant;
    logic [2:0] id;
    logic busy, start;
    logic [5:0] prio;
  } vec_t;
  vec_t vecs[$];
  ring_rr_arbiter_6 #(.N(6), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_id(grant_id),
    .busy(busy), .grant_start(grant_start), .prio(prio), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [5:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask
  task automatic check_all(input string tag, input logic [5:0] g, input logic [2:0] id, input logic b,
                           input logic s, input logic [5:0] p, input logic to);
    chk({tag, " grant"}, 8'(grant), 8'(g));
    chk({tag, " grant_id"}, 8'(grant_id), 8'(id));
    chk({tag, " busy"}, 8'(busy), 8'(b));
    chk({tag, " grant_start"}, 8'(grant_start), 8'(s));
    chk({tag, " prio"}, 8'(prio), 8'(p));
    chk({tag, " timeout"}, 8'(timeout), 8'(to));
  endtask
  function automatic void add(input logic r, input logic [5:0] q, input logic [5:0] g, input logic [2:0] id,
                              input logic b, input logic s, input logic [5:0] p);
    vec_t v;
    v.rst = r; v.req = q; v.grant = g; v.id = id; v.busy = b; v.start = s; v.prio = p;
    vecs.push_back(v);
  endfunction
  initial begin
    logic [5:0] eg, ep;
    logic es, et;
    int ph;
    add(1, 6'h3F, 6'h00, 0, 0, 0, 6'h01);
    add(1, 6'h3F, 6'h00, 0, 0, 0, 6'h01);
    for (int i = 0; i < 6; i++) begin
      add(0, 6'h3F, 6'(1 << i), 3'(i), 1, 1, 6'(1 << i));
      add(0, 6'h3F, 6'(1 << i), 3'(i), 1, 0, 6'(1 << i));
      add(0, 6'h3F & ~6'(1 << i), 6'h00, 0, 0, 0, 6'(1 << ((i + 1) % 6)));
    end
    add(0, 6'h3F, 6'h01, 0, 1, 1, 6'h01);
    add(0, 6'h3E, 6'h00, 0, 0, 0, 6'h02);
    add(0, 6'h04, 6'h04, 2, 1, 1, 6'h02);
    add(0, 6'h00, 6'h00, 0, 0, 0, 6'h08);
    add(0, 6'h00, 6'h00, 0, 0, 0, 6'h08);
    add(0, 6'h10, 6'h10, 4, 1, 1, 6'h08);
    add(0, 6'h00, 6'h00, 0, 0, 0, 6'h20);
    add(0, 6'h03, 6'h01, 0, 1, 1, 6'h20);
    add(0, 6'h00, 6'h00, 0, 0, 0, 6'h02);
    add(0, 6'h10, 6'h10, 4, 1, 1, 6'h02);
    add(0, 6'h00, 6'h00, 0, 0, 0, 6'h20);
    add(0, 6'h21, 6'h20, 5, 1, 1, 6'h20);
    add(0, 6'h00, 6'h00, 0, 0, 0, 6'h01);
    add(0, 6'h02, 6'h02, 1, 1, 1, 6'h01);
    add(0, 6'h00, 6'h00, 0, 0, 0, 6'h04);
    add(0, 6'h23, 6'h20, 5, 1, 1, 6'h04);
    add(0, 6'h3F, 6'h20, 5, 1, 0, 6'h04);
    add(0, 6'h1F, 6'h00, 0, 0, 0, 6'h01);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req);
      check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].id, vecs[i].busy, vecs[i].start, vecs[i].prio, 1'b0);
    end
    for (int c = 1; c <= 20; c++) begin
      step(0, 6'h01);
      ph = (c - 1) % 9;
`ifdef RING_ARB_TIMEOUT_EN
      eg = ph != 8 ? 6'h01 : 6'h00;
      es = ph == 0;
      et = ph == 8;
      ep = c < 9 ? 6'h01 : 6'h02;
`else
      eg = 6'h01;
      es = c == 1;
      et = 1'b0;
      ep = 6'h01;
`endif
      check_all($sformatf("hold%0d", c), eg, 3'd0, |eg, es, ep, et);
    end
    step(0, 6'h00);
    check_all("hold_release", 6'h00, 0, 0, 0, 6'h02, 0);
    step(0, 6'h08);
    check_all("rstmid c1", 6'h08, 3, 1, 1, 6'h02, 0);
    step(0, 6'h08);
    check_all("rstmid c2", 6'h08, 3, 1, 0, 6'h02, 0);
    step(1, 6'h09);
    check_all("rstmid rst", 6'h00, 0, 0, 0, 6'h01, 0);
    step(0, 6'h09);
    check_all("rstmid regrant", 6'h01, 0, 1, 1, 6'h01, 0);
    step(0, 6'h08);
    check_all("rstmid release", 6'h00, 0, 0, 0, 6'h02, 0);
    step(0, 6'h08);
    check_all("rstmid next", 6'h08, 3, 1, 1, 6'h02, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
